// File: rtl/shift_engine_n.sv
// Shift/rotate/load register with single-step ops and counted burst mode.
// Burst FSM: IDLE -> RUN (latched op, N enabled edges) -> DONE pulse.
module shift_engine_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_nxt;
  logic             w_legal;

  function automatic logic [WIDTH-1:0] f_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] p
  );
    case (m)
      3'b001:  f_op = {v[WIDTH-2:0], sr};
      3'b010:  f_op = {sl, v[WIDTH-1:1]};
      3'b011:  f_op = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  f_op = {v[0], v[WIDTH-1:1]};
      3'b101:  f_op = p;
      3'b110:  f_op = '0;
      default: f_op = v;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_legal     = (mode >= 3'd1) && (mode <= 3'd4);
    unique case (1'b1)
      (r_state == RUN): begin
        // en=0 stalls everything, inputs ignored
        if (en) begin
          w_q_nxt   = f_op(r_mode, r_q, ser_in_l,
                           ser_in_r, par_in);
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        if (start && w_legal) begin
          w_mode_nxt  = mode;
          w_cnt_nxt   = shift_cnt;
          w_state_nxt = (shift_cnt == '0) ? DONE : RUN;
        end else if (en) begin
          w_q_nxt = f_op(mode, r_q, ser_in_l,
                         ser_in_r, par_in);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign q         = r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule
